// File: rtl/mux_nto1_pipe.sv
// Registered NUM_IN-to-1 multiplexer with a valid/ready handshake and a two-entry skid buffer.
// Optional out-of-range select checking (zeroed word plus sticky sel_err) is enabled by MUX_SEL_CHECK_EN.
module mux_nto1_pipe #(
   parameter int N      = 32,
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IN*N-1:0] in_data,
   input  logic [SEL_W-1:0]    sel,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [N-1:0]        out_data,
   output logic                out_valid,
   input  logic                out_ready,
`ifdef MUX_SEL_CHECK_EN
   output logic                sel_err,
`endif
   output logic [1:0]          dbg_state
);

   // Handshake: a word moves on any edge where valid & ready are both high; a producer
   // holding valid keeps its payload stable, and ready never depends on the same-cycle valid.
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   out_q, out_d;
   logic [N-1:0]   skid_q, skid_d;
   logic [N-1:0]   sel_word;
   logic           accept, drain;
`ifdef MUX_SEL_CHECK_EN
   logic           sel_oob;
   logic           sel_err_q, sel_err_d;
`endif

   // Unmatched selects fall through to input 0 unless the check build zeroes them.
   always_comb begin
      sel_word = in_data[N-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) sel_word = in_data[k*N +: N];
      end
`ifdef MUX_SEL_CHECK_EN
      sel_oob = (int'(sel) >= NUM_IN);
      if (sel_oob) sel_word = '0;
`endif
   end

   assign in_ready  = (state_q != TWO) & ~rst;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_q;
   assign dbg_state = state_q;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               out_d   = sel_word;
            end
         end
         ONE: begin
            if (accept && drain) begin
               out_d = sel_word;
            end else if (accept) begin
               state_d = TWO;
               skid_d  = sel_word;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (drain) begin
               state_d = ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

`ifdef MUX_SEL_CHECK_EN
   always_comb begin
      sel_err_d = sel_err_q | (accept & sel_oob);
   end
   assign sel_err = sel_err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

`ifdef MUX_SEL_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) sel_err_q <= 1'b0;
      else     sel_err_q <= sel_err_d;
   end
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: a 4-input instance driven from a vector table plus
// hand sequences, and a 5-input instance for out-of-range select (MUX_SEL_CHECK_EN aware).
module tb_mux_nto1_pipe;

   localparam logic [31:0] VA = 32'h11111111;
   localparam logic [31:0] VB = 32'h22222222;
   localparam logic [31:0] VC = 32'h33333333;
   localparam logic [31:0] VD = 32'h44444444;
   localparam logic [1:0]  S_EMPTY = 2'd0;
   localparam logic [1:0]  S_TWO   = 2'd2;

   logic          clk = 1'b0;
   logic          rst;
   logic [127:0]  in_data4;
   logic [1:0]    sel4;
   logic          in_valid4, in_ready4, out_valid4, out_ready4;
   logic [31:0]   out_data4;
   logic [1:0]    dbg4;
   logic [159:0]  in_data5;
   logic [2:0]    sel5;
   logic          in_valid5, in_ready5, out_valid5, out_ready5;
   logic [31:0]   out_data5;
   logic [1:0]    dbg5;
`ifdef MUX_SEL_CHECK_EN
   logic          sel_err4, sel_err5;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_nto1_pipe #(.N(32), .NUM_IN(4)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel4), .in_valid(in_valid4),
      .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
`ifdef MUX_SEL_CHECK_EN
      .sel_err(sel_err4),
`endif
      .dbg_state(dbg4)
   );

   mux_nto1_pipe #(.N(32), .NUM_IN(5)) dut5 (
      .clk(clk), .rst(rst), .in_data(in_data5), .sel(sel5), .in_valid(in_valid5),
      .in_ready(in_ready5), .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
`ifdef MUX_SEL_CHECK_EN
      .sel_err(sel_err5),
`endif
      .dbg_state(dbg5)
   );

   typedef struct {
      logic        iv;
      logic [1:0]  sel;
      logic        ordy;
      logic        ov;
      logic [31:0] od;
      logic        chk_d;
      logic        ir;
   } vec_t;

   vec_t vecs[16];
   int   n_tab;

   function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic ordy,
                               input logic ov, input logic [31:0] od, input logic chk_d,
                               input logic ir);
      vec_t v;
      v.iv = iv; v.sel = sel; v.ordy = ordy; v.ov = ov; v.od = od; v.chk_d = chk_d; v.ir = ir;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(input logic iv, input logic [1:0] s, input logic ordy);
      in_valid4  = iv;
      sel4       = s;
      out_ready4 = ordy;
   endtask

   initial begin
      logic [31:0] exp5;
      rst        = 1'b1;
      in_data4   = {VD, VC, VB, VA};
      in_data5   = {32'hE4E4E4E4, 32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
      drive4(1'b0, 2'd0, 1'b1);
      in_valid5  = 1'b0;
      sel5       = 3'd0;
      out_ready5 = 1'b1;

      // Reset state
      step();
      step();
      chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
      chk("rst_out_data", out_data4, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready4}, 32'd0);
      chk("rst_state", {30'd0, dbg4}, {30'd0, S_EMPTY});
      chk("rst_out_valid5", {31'd0, out_valid5}, 32'd0);
`ifdef MUX_SEL_CHECK_EN
      chk("rst_sel_err", {31'd0, sel_err5}, 32'd0);
`endif
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready4}, 32'd1);

      // Per row: inputs held for one edge, outputs sampled just after it
      n_tab = 0;
      vecs[n_tab++] = mk(1, 2'd2, 1, 1, VC, 1, 1);
      vecs[n_tab++] = mk(1, 2'd0, 1, 1, VA, 1, 1);
      vecs[n_tab++] = mk(1, 2'd1, 1, 1, VB, 1, 1);
      vecs[n_tab++] = mk(1, 2'd2, 1, 1, VC, 1, 1);
      vecs[n_tab++] = mk(1, 2'd3, 1, 1, VD, 1, 1);
      vecs[n_tab++] = mk(1, 2'd3, 1, 1, VD, 1, 1);
      vecs[n_tab++] = mk(1, 2'd0, 1, 1, VA, 1, 1);
      vecs[n_tab++] = mk(0, 2'd0, 1, 0, '0, 0, 1);
      vecs[n_tab++] = mk(1, 2'd1, 0, 1, VB, 1, 1);
      vecs[n_tab++] = mk(1, 2'd3, 0, 1, VB, 1, 0);
      vecs[n_tab++] = mk(1, 2'd0, 0, 1, VB, 1, 0);
      vecs[n_tab++] = mk(0, 2'd0, 1, 1, VD, 1, 1);
      vecs[n_tab++] = mk(0, 2'd0, 1, 0, '0, 0, 1);
      vecs[n_tab++] = mk(1, 2'd2, 0, 1, VC, 1, 1);
      vecs[n_tab++] = mk(0, 2'd0, 0, 1, VC, 1, 1);
      vecs[n_tab++] = mk(1, 2'd1, 1, 1, VB, 1, 1);
      for (int i = 0; i < n_tab; i++) begin
         drive4(vecs[i].iv, vecs[i].sel, vecs[i].ordy);
         step();
         chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid4}, {31'd0, vecs[i].ov});
         if (vecs[i].chk_d) chk($sformatf("vec%0d_out_data", i), out_data4, vecs[i].od);
         chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready4}, {31'd0, vecs[i].ir});
      end
      drive4(0, 2'd0, 1);
      step();
      chk("drain_empty", {31'd0, out_valid4}, 32'd0);

      // Capture isolation for both the output and skid entries
      drive4(1, 2'd1, 0);
      step();
      drive4(1, 2'd2, 0);
      step();
      chk("iso_state_two", {30'd0, dbg4}, {30'd0, S_TWO});
      drive4(0, 2'd3, 0);
      in_data4 = {4{32'hDEADBEEF}};
      step();
      chk("iso_hold_b", out_data4, VB);
      out_ready4 = 1'b1;
      step();
      chk("iso_skid_c", out_data4, VC);
      chk("iso_skid_valid", {31'd0, out_valid4}, 32'd1);
      step();
      chk("iso_empty", {31'd0, out_valid4}, 32'd0);
      in_data4 = {VD, VC, VB, VA};

      // Reset while two words are held
      drive4(1, 2'd0, 0);
      step();
      sel4 = 2'd1;
      step();
      chk("mid_state_two", {30'd0, dbg4}, {30'd0, S_TWO});
      drive4(0, 2'd0, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", {31'd0, in_ready4}, 32'd0);
      step();
      chk("mid_rst_out_valid", {31'd0, out_valid4}, 32'd0);
      chk("mid_rst_in_ready2", {31'd0, in_ready4}, 32'd0);
      rst = 1'b0;
      #1;
      chk("mid_post_in_ready", {31'd0, in_ready4}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("mid_no_stale%0d", i), {31'd0, out_valid4}, 32'd0);
      end

      // Out-of-range select on the 5-input instance
`ifdef MUX_SEL_CHECK_EN
      exp5 = 32'd0;
`else
      exp5 = 32'hE0E0E0E0;
`endif
      in_valid5 = 1'b1;
      sel5      = 3'd6;
      step();
      chk("oob_out_valid", {31'd0, out_valid5}, 32'd1);
      chk("oob_out_data", out_data5, exp5);
`ifdef MUX_SEL_CHECK_EN
      chk("oob_sel_err", {31'd0, sel_err5}, 32'd1);
`endif
      sel5 = 3'd4;
      step();
      chk("in4_out_data", out_data5, 32'hE4E4E4E4);
`ifdef MUX_SEL_CHECK_EN
      chk("sel_err_sticky", {31'd0, sel_err5}, 32'd1);
`endif
      sel5 = 3'd2;
      step();
      chk("in2_out_data", out_data5, 32'hE2E2E2E2);
      in_valid5 = 1'b0;
      step();
      chk("dut5_empty", {31'd0, out_valid5}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
